// File: rtl/fifo_dispatch_pkg.sv
// Shared types and default geometry for the ingress-to-destination dispatcher.
// Imported by the dispatcher top and its control FSM.
package fifo_dispatch_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int DEST_W_DEF = 2;
    localparam int CNT_W_DEF  = 16;
    localparam int N_DEST     = 1 << DEST_W_DEF;
    localparam int DEST_MSB   = DATA_W_DEF - 1;
    localparam int DEST_LSB   = DATA_W_DEF - DEST_W_DEF;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/fifo_dispatch_fsm.sv
// Control FSM for the dispatcher: state register, next-state logic and
// registered idle/active/error decodes.
module dispatch_fsm
    import fifo_dispatch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   init,
    input  logic   rd_en,
    input  logic   in_flight,
    input  logic   overflow,
    output state_t state,
    output logic   idle_out,
    output logic   active_out,
    output logic   error_out
);

    state_t state_q;
    state_t state_d;

    // State register; the decodes follow the next state so they match state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_out   <= (state_d == ST_IDLE);
            active_out <= (state_d == ST_ACTIVE);
            error_out  <= (state_d == ST_ERROR);
        end
    end

    // Next state: ERROR is absorbing, overflow beats init, init beats the rest.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_ERROR) begin
            state_d = ST_ERROR;
        end else if (overflow) begin
            state_d = ST_ERROR;
        end else if (init) begin
            state_d = ST_INIT;
        end else begin
            unique case (state_q)
                ST_RESET:  state_d = ST_INIT;
                ST_INIT:   if (!in_flight) state_d = ST_IDLE;
                ST_IDLE:   if (rd_en) state_d = ST_ACTIVE;
                ST_ACTIVE: if (!rd_en && !in_flight) state_d = ST_IDLE;
                default:   state_d = state_q;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/fifo_dispatch.sv
// Pops the ingress FIFO and routes each word by its top bits to one of the
// destination FIFOs, two cycles after the pop; counts writes, flags overflow.
module fifo_dispatch
    import fifo_dispatch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic                   src_empty,
    input  logic [DATA_W-1:0]      src_data,
    output logic                   src_rd_en,
    input  logic [(1<<DEST_W)-1:0] dst_almost_full,
    input  logic [(1<<DEST_W)-1:0] dst_full,
    output logic [(1<<DEST_W)-1:0] dst_wr_en,
    output logic [DATA_W-1:0]      dst_data,
    output logic                   idle_out,
    output logic                   active_out,
    output logic                   error_out,
    output logic [CNT_W-1:0]       disp_count
);

    localparam int NDST = 1 << DEST_W;

    state_t            state;
    logic              rd_pend;
    logic              s1_v;
    logic [DATA_W-1:0] s1_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DEST_W-1:0] dest;
    logic              run_ok;
    logic              hit;
    logic              overflow;
    logic              wr;
    logic              in_flight;

    // Any almost_full throttles: the next word's destination is not known yet.
    assign run_ok    = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign src_rd_en = run_ok & ~init & ~src_empty
                     & ~|dst_almost_full & ~error_out;

    assign dest      = s1_q[DATA_W-1 -: DEST_W];
    assign hit       = s1_v & (state != ST_ERROR);
    assign overflow  = hit & dst_full[dest];
    assign wr        = hit & ~dst_full[dest];
    assign in_flight = rd_pend | s1_v;

    assign dst_wr_en  = wr ? (NDST'(1) << dest) : '0;
    assign dst_data   = s1_q;
    assign disp_count = cnt_q;

    // Two-slot pipeline (pending read, captured word) and the write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            s1_v    <= 1'b0;
            s1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            rd_pend <= src_rd_en;
            s1_v    <= rd_pend;
            if (rd_pend) s1_q <= src_data;
            if (wr) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    dispatch_fsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .rd_en      (src_rd_en),
        .in_flight  (in_flight),
        .overflow   (overflow),
        .state      (state),
        .idle_out   (idle_out),
        .active_out (active_out),
        .error_out  (error_out)
    );

endmodule

// File: tb/tb_fifo_dispatch.sv
// Directed and randomized bench for fifo_dispatch against a queue-based
// model of the source FIFO, the 2-cycle delivery latency and the modes.
module tb_fifo_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        src_empty;
    logic [9:0]  src_data;
    logic        src_rd_en;
    logic [3:0]  dst_almost_full;
    logic [3:0]  dst_full;
    logic [3:0]  dst_wr_en;
    logic [9:0]  dst_data;
    logic        idle_out;
    logic        active_out;
    logic        error_out;
    logic [15:0] disp_count;

    always #5 clk = ~clk;

    fifo_dispatch #(.DATA_W(10), .DEST_W(2), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .src_empty       (src_empty),
        .src_data        (src_data),
        .src_rd_en       (src_rd_en),
        .dst_almost_full (dst_almost_full),
        .dst_full        (dst_full),
        .dst_wr_en       (dst_wr_en),
        .dst_data        (dst_data),
        .idle_out        (idle_out),
        .active_out      (active_out),
        .error_out       (error_out),
        .disp_count      (disp_count)
    );

    localparam int M_RST  = 0;
    localparam int M_INIT = 1;
    localparam int M_IDLE = 2;
    localparam int M_ACT  = 3;
    localparam int M_ERR  = 4;

    typedef struct {
        logic [9:0] w;
        int          due;
    } fl_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         mst     = M_RST;
    int         mcnt    = 0;
    bit         chk     = 1'b0;
    logic [9:0] src_q[$];
    fl_t        fl[$];

    task automatic chk1(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [9:0] w);
        src_q.push_back(w);
        src_empty = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit         erd;
        bit         ov;
        bit         due;
        bit         infl;
        logic [3:0] ewr;
        logic [9:0] ed;
        logic [9:0] w;
        @(negedge clk);
        erd = (mst == M_IDLE || mst == M_ACT) && !init && !src_empty
              && dst_almost_full == 4'b0;
        ewr = 4'b0;
        ed  = 10'b0;
        ov  = 1'b0;
        due = fl.size() > 0 && fl[0].due == cyc;
        if (due && mst != M_ERR) begin
            if (dst_full[fl[0].w[9:8]]) ov = 1'b1;
            else begin
                ewr = 4'b1 << fl[0].w[9:8];
                ed  = fl[0].w;
            end
        end
        if (chk) begin
            chk1("rd_en", src_rd_en, erd);
            chk1("wr_en", dst_wr_en, ewr);
            if (ewr != 4'b0) chk1("dst_data", dst_data, ed);
            chk1("disp_count", disp_count, mcnt);
            chk1("idle_out", idle_out, mst == M_IDLE);
            chk1("active_out", active_out, mst == M_ACT);
            chk1("error_out", error_out, mst == M_ERR);
        end
        @(posedge clk);
        infl = fl.size() > 0;
        if (due) fl.delete(0);
        w = src_data;
        if (erd) w = src_q.pop_front();
        if (reset) begin
            mst  = M_RST;
            mcnt = 0;
            fl.delete();
        end else begin
            if (ewr != 4'b0) mcnt = (mcnt + 1) % 65536;
            if (mst == M_ERR) mst = M_ERR;
            else if (ov) mst = M_ERR;
            else if (init) mst = M_INIT;
            else if (mst == M_RST) mst = M_INIT;
            else if (mst == M_INIT && !infl) mst = M_IDLE;
            else if (mst == M_IDLE && erd) mst = M_ACT;
            else if (mst == M_ACT && !erd && !infl) mst = M_IDLE;
            if (erd) fl.push_back('{w: w, due: cyc + 2});
        end
        cyc++;
        #1;
        src_data  = w;
        src_empty = (src_q.size() == 0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        reset           = 1'b1;
        init            = 1'b0;
        src_data        = 10'b0;
        src_empty       = 1'b1;
        dst_almost_full = 4'b0;
        dst_full        = 4'b0;

        // T1 reset with a non-empty source, then T2 stream of 8 words.
        for (int i = 0; i < 8; i++) put({2'(i % 4), 8'(i * 37 + 17)});
        step();
        chk = 1'b1;
        step();
        #1;
        chk1("t1_rd_en", src_rd_en, 0);
        chk1("t1_wr_en", dst_wr_en, 0);
        chk1("t1_data", dst_data, 0);
        chk1("t1_count", disp_count, 0);
        chk1("t1_error", error_out, 0);
        reset = 1'b0;
        run(16);
        #1;
        chk1("t2_count", disp_count, 8);
        chk1("t2_idle", idle_out, 1);

        // T3 throttle on one almost_full mid-stream.
        for (int i = 0; i < 12; i++) put(10'($urandom));
        run(3);
        dst_almost_full = 4'b0100;
        run(3);
        dst_almost_full = 4'b0;
        run(16);
        #1;
        chk1("t3_count", disp_count, 20);

        // T4 overflow on destination 1.
        dst_full = 4'b0010;
        for (int i = 0; i < 6; i++) put({2'b01, 8'($urandom)});
        run(8);
        #1;
        chk1("t4_error", error_out, 1);
        chk1("t4_rd_en", src_rd_en, 0);
        chk1("t4_count", disp_count, 20);
        run(3);
        dst_full = 4'b0;
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(14);

        // T5 init while streaming, then release.
        for (int i = 0; i < 12; i++) put(10'($urandom));
        run(3);
        init = 1'b1;
        run(5);
        #1;
        chk1("t5_rd_en", src_rd_en, 0);
        chk1("t5_active", active_out, 0);
        init = 1'b0;
        run(18);

        // T6 reset with words in flight.
        for (int i = 0; i < 10; i++) put(10'($urandom));
        run(4);
        reset = 1'b1;
        run(1);
        #1;
        chk1("t6_wr_en", dst_wr_en, 0);
        chk1("t6_count", disp_count, 0);
        reset = 1'b0;
        run(20);

        // Randomized traffic, throttling, init, rare overflow and reset.
        repeat (600) begin
            if ($urandom_range(0, 2) != 0 && src_q.size() < 8)
                put(10'($urandom));
            dst_almost_full = ($urandom_range(0, 7) == 0)
                            ? 4'($urandom_range(1, 15)) : 4'b0;
            dst_full = ($urandom_range(0, 79) == 0)
                     ? 4'($urandom_range(1, 15)) : 4'b0;
            if ($urandom_range(0, 24) == 0) init = ~init;
            reset = ($urandom_range(0, 59) == 0);
            step();
        end
        reset           = 1'b0;
        init            = 1'b0;
        dst_almost_full = 4'b0;
        dst_full        = 4'b0;
        run(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
